// File: rtl/logic_op_arbiter.sv
// One registered bitwise logic unit shared round-robin among NREQ requesters.
// Results leave through a single valid/ready slot, tagged with the requester index and opcode.
module logic_op_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [3*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] a_in,
   input  logic [WIDTH*NREQ-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_data,
   output logic [IDW-1:0]        res_id,
   output logic [2:0]            res_op,
   output logic                  res_err,
   output logic                  busy,
   output logic [CNTW-1:0]       op_count
);

   typedef enum logic {EMPTY, FULL} slotState_t;

   slotState_t       r_state;
   slotState_t       w_nextState;
   logic [IDW-1:0]   r_lastGrant;
   logic [WIDTH-1:0] r_data;
   logic [IDW-1:0]   r_id;
   logic [2:0]       r_op;
   logic             r_err;
   logic [CNTW-1:0]  r_count;

   logic [2:0]       w_opArr [NREQ];
   logic [WIDTH-1:0] w_aArr  [NREQ];
   logic [WIDTH-1:0] w_bArr  [NREQ];

   logic             w_found;
   logic [IDW-1:0]   w_winner;
   logic [IDW-1:0]   w_searchIdx;
   logic             w_accept;
   logic [2:0]       w_selOp;
   logic [WIDTH-1:0] w_selA;
   logic [WIDTH-1:0] w_selB;
   logic [WIDTH-1:0] w_result;
   logic             w_resErr;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_opArr[g] = op[3*g +: 3];
      assign w_aArr[g]  = a_in[WIDTH*g +: WIDTH];
      assign w_bArr[g]  = b_in[WIDTH*g +: WIDTH];
   end

   // Search starts one past the last winner and wraps, so every requester is reached within NREQ grants.
   always_comb begin
      w_found     = 1'b0;
      w_winner    = r_lastGrant;
      w_searchIdx = r_lastGrant;
      for (int k = 0; k < NREQ; k++) begin
         if (w_searchIdx == IDW'(NREQ - 1)) begin
            w_searchIdx = '0;
         end else begin
            w_searchIdx = w_searchIdx + 1'b1;
         end
         if (!w_found && req[w_searchIdx]) begin
            w_found  = 1'b1;
            w_winner = w_searchIdx;
         end
      end
   end

   assign w_accept = !rst && w_found && ((r_state == EMPTY) || res_ready);

   always_comb begin
      gnt = '0;
      if (w_accept) begin
         gnt[w_winner] = 1'b1;
      end
   end

   assign w_selOp = w_opArr[w_winner];
   assign w_selA  = w_aArr[w_winner];
   assign w_selB  = w_bArr[w_winner];

   always_comb begin
      w_result = '0;
      w_resErr = 1'b0;
      case (w_selOp)
         3'd0:    w_result = w_selA & w_selB;
         3'd1:    w_result = w_selA | w_selB;
         3'd2:    w_result = ~w_selA;
         3'd3:    w_result = ~(w_selA & w_selB);
         3'd4:    w_result = ~(w_selA | w_selB);
         3'd5:    w_result = w_selA ^ w_selB;
         3'd6:    w_result = ~(w_selA ^ w_selB);
         default: w_resErr = 1'b1;
      endcase
   end

   // A drain and a fill on the same edge keep the slot FULL for back-to-back throughput.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         EMPTY: if (w_accept) w_nextState = FULL;
         FULL:  if (res_ready && !w_accept) w_nextState = EMPTY;
         default: w_nextState = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastGrant <= IDW'(NREQ - 1);
         r_data      <= '0;
         r_id        <= '0;
         r_op        <= '0;
         r_err       <= 1'b0;
         r_count     <= '0;
      end else begin
         if (w_accept) begin
            r_lastGrant <= w_winner;
            r_data      <= w_result;
            r_id        <= w_winner;
            r_op        <= w_selOp;
            r_err       <= w_resErr;
         end
         if ((r_state == FULL) && res_ready && (r_count != {CNTW{1'b1}})) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign res_valid = (r_state == FULL);
   assign res_data  = r_data;
   assign res_id    = r_id;
   assign res_op    = r_op;
   assign res_err   = r_err;
   assign op_count  = r_count;
   assign busy      = res_valid | (|req);

endmodule
